// File: rtl/gmsk_freq_disc.sv
// rtl/gmsk_freq_disc.sv - GMSK frequency discriminator and per-symbol hard slicer
//
// Takes one CORDIC phase sample per phase_valid strobe, forms the wrapped
// phase difference against the previous accepted sample, saturates it to
// FREQ_W bits, integrates SPS differences and slices the sum into one bit.
//
// Ports:
//   clk, rst      system clock, synchronous active-high reset
//   en            block enable; low returns to IDLE and clears the integrator
//   phase_in      unsigned phase code, legal range 0..FULL_SCALE-1
//   phase_valid   single-cycle strobe qualifying phase_in
//   sym_align     restart symbol integration
//   freq_out      wrapped, saturated phase difference (signed, held)
//   freq_valid    one-cycle pulse with each new freq_out
//   acc_out       integrator sum at symbol end (signed, held)
//   bit_out       hard decision, 1 when acc_out >= 0
//   bit_valid     one-cycle pulse with each new bit_out
//   sat_flag      sticky: a difference was clipped
//   range_err     sticky: an out-of-range phase was received
module gmsk_freq_disc #(
  parameter int PHASE_W    = 9,
  parameter int FULL_SCALE = 360,
  parameter int FREQ_W     = 8,
  parameter int SPS        = 20,
  parameter int ACC_W      = FREQ_W + $clog2(SPS) + 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [PHASE_W-1:0]       phase_in,
  input  logic                     phase_valid,
  input  logic                     sym_align,
  output logic signed [FREQ_W-1:0] freq_out,
  output logic                     freq_valid,
  output logic signed [ACC_W-1:0]  acc_out,
  output logic                     bit_out,
  output logic                     bit_valid,
  output logic                     sat_flag,
  output logic                     range_err
);

  localparam int DW    = PHASE_W + 2;
  localparam int CNT_W = $clog2(SPS + 1);
  localparam int SAT_MAX = 2 ** (FREQ_W - 1) - 1;
  localparam int SAT_MIN = -(2 ** (FREQ_W - 1));

  localparam logic signed [DW-1:0]  FS_S   = DW'(FULL_SCALE);
  localparam logic signed [DW-1:0]  HALF_S = DW'(FULL_SCALE / 2);
  localparam logic [PHASE_W:0]      FS_U   = (PHASE_W + 1)'(FULL_SCALE);
  localparam logic [CNT_W-1:0]      SPS_C  = CNT_W'(SPS);

  typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

  state_t                    state_q, state_d;
  logic [PHASE_W-1:0]        prev_q, prev_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic signed [FREQ_W-1:0]  freq_out_q, freq_out_d;
  logic                      freq_valid_q, freq_valid_d;
  logic signed [ACC_W-1:0]   acc_out_q, acc_out_d;
  logic                      bit_out_q, bit_out_d;
  logic                      bit_valid_q, bit_valid_d;
  logic                      sat_q, sat_d;
  logic                      rerr_q, rerr_d;
  // Completed symbol waiting one cycle so bit_valid trails its freq_valid.
  logic                      done_q, done_d;
  logic signed [ACC_W-1:0]   done_sum_q, done_sum_d;

  logic                      legal, accept;
  logic signed [DW-1:0]      diff_raw, diff_w;
  logic signed [31:0]        d_wide;
  logic                      over, under;
  logic signed [FREQ_W-1:0]  freq_clip;
  logic signed [ACC_W-1:0]   d_acc, acc_sum;
  logic [CNT_W-1:0]          cnt_next;

  always_comb begin
    legal  = {1'b0, phase_in} < FS_U;
    accept = phase_valid && legal;

    // Modular subtraction in DW bits, then fold into (-FS/2, +FS/2].
    diff_raw = {2'b00, phase_in} - {2'b00, prev_q};
    diff_w   = diff_raw;
    if (diff_raw > HALF_S) begin
      diff_w = diff_raw - FS_S;
    end else if (diff_raw <= -HALF_S) begin
      diff_w = diff_raw + FS_S;
    end

    d_wide    = {{(32 - DW){diff_w[DW-1]}}, diff_w};
    over      = d_wide > SAT_MAX;
    under     = d_wide < SAT_MIN;
    freq_clip = over ? FREQ_W'(SAT_MAX) : (under ? FREQ_W'(SAT_MIN) : d_wide[FREQ_W-1:0]);

    d_acc    = {{(ACC_W - FREQ_W){freq_clip[FREQ_W-1]}}, freq_clip};
    acc_sum  = acc_q + d_acc;
    cnt_next = cnt_q + CNT_W'(1);

    state_d      = state_q;
    prev_d       = prev_q;
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    freq_out_d   = freq_out_q;
    freq_valid_d = 1'b0;
    acc_out_d    = acc_out_q;
    bit_out_d    = bit_out_q;
    bit_valid_d  = 1'b0;
    sat_d        = sat_q;
    rerr_d       = rerr_q;
    done_d       = 1'b0;
    done_sum_d   = done_sum_q;

    if (done_q) begin
      acc_out_d   = done_sum_q;
      bit_out_d   = ~done_sum_q[ACC_W-1];
      bit_valid_d = 1'b1;
    end

    if (phase_valid && !legal) begin
      rerr_d = 1'b1;
    end

    if (!en) begin
      state_d = IDLE;
      acc_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: state_d = PRIME;
        PRIME: begin
          if (sym_align) begin
            acc_d = '0;
            cnt_d = '0;
          end
          if (accept) begin
            prev_d  = phase_in;
            state_d = RUN;
          end
        end
        RUN: begin
          if (accept) begin
            prev_d       = phase_in;
            freq_out_d   = freq_clip;
            freq_valid_d = 1'b1;
            if (over || under) begin
              sat_d = 1'b1;
            end
            // sym_align takes precedence over a symbol-completing sample.
            if (sym_align) begin
              acc_d = d_acc;
              cnt_d = CNT_W'(1);
            end else if (cnt_next == SPS_C) begin
              done_d     = 1'b1;
              done_sum_d = acc_sum;
              acc_d      = '0;
              cnt_d      = '0;
            end else begin
              acc_d = acc_sum;
              cnt_d = cnt_next;
            end
          end else if (sym_align) begin
            acc_d = '0;
            cnt_d = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      prev_q       <= '0;
      acc_q        <= '0;
      cnt_q        <= '0;
      freq_out_q   <= '0;
      freq_valid_q <= 1'b0;
      acc_out_q    <= '0;
      bit_out_q    <= 1'b0;
      bit_valid_q  <= 1'b0;
      sat_q        <= 1'b0;
      rerr_q       <= 1'b0;
      done_q       <= 1'b0;
      done_sum_q   <= '0;
    end else begin
      state_q      <= state_d;
      prev_q       <= prev_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      freq_out_q   <= freq_out_d;
      freq_valid_q <= freq_valid_d;
      acc_out_q    <= acc_out_d;
      bit_out_q    <= bit_out_d;
      bit_valid_q  <= bit_valid_d;
      sat_q        <= sat_d;
      rerr_q       <= rerr_d;
      done_q       <= done_d;
      done_sum_q   <= done_sum_d;
    end
  end

  assign freq_out   = freq_out_q;
  assign freq_valid = freq_valid_q;
  assign acc_out    = acc_out_q;
  assign bit_out    = bit_out_q;
  assign bit_valid  = bit_valid_q;
  assign sat_flag   = sat_q;
  assign range_err  = rerr_q;

endmodule

// File: tb/tb_gmsk_freq_disc.sv
// tb/tb_gmsk_freq_disc.sv - directed self-checking bench for gmsk_freq_disc
module tb_gmsk_freq_disc;

  logic              clk;
  logic              rst;
  logic              en;
  logic [8:0]        phase_in;
  logic              phase_valid;
  logic              sym_align;
  logic signed [7:0] freq_out;
  logic              freq_valid;
  logic signed [13:0] acc_out;
  logic              bit_out;
  logic              bit_valid;
  logic              sat_flag;
  logic              range_err;

  int vecs = 0;
  int errs = 0;
  int nbits = 0;
  int last_acc = 0;
  int last_bit = 0;
  int cur = 0;

  gmsk_freq_disc dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .phase_in    (phase_in),
    .phase_valid (phase_valid),
    .sym_align   (sym_align),
    .freq_out    (freq_out),
    .freq_valid  (freq_valid),
    .acc_out     (acc_out),
    .bit_out     (bit_out),
    .bit_valid   (bit_valid),
    .sat_flag    (sat_flag),
    .range_err   (range_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    vecs++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // Apply inputs for one clock edge; outputs are sampled 1 time unit after it.
  task automatic step(input int ph, input bit pv, input bit al);
    phase_in    = ph[8:0];
    phase_valid = pv;
    sym_align   = al;
    @(posedge clk);
    #1;
    if (bit_valid) begin
      nbits++;
      last_acc = int'(acc_out);
      last_bit = int'(bit_out);
    end
  endtask

  task automatic idle();
    step(cur, 1'b0, 1'b0);
  endtask

  task automatic ramp(input int n, input int delta);
    for (int i = 0; i < n; i++) begin
      cur = cur + delta;
      step(cur, 1'b1, 1'b0);
    end
  endtask

  task automatic restart();
    rst = 1'b1;
    en  = 1'b1;
    step(0, 1'b0, 1'b0);
    rst = 1'b0;
    step(0, 1'b0, 1'b0);
    nbits = 0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_fo"}, int'(freq_out), 0);
    chk({tag, "_fv"}, int'(freq_valid), 0);
    chk({tag, "_acc"}, int'(acc_out), 0);
    chk({tag, "_bit"}, int'(bit_out), 0);
    chk({tag, "_bv"}, int'(bit_valid), 0);
    chk({tag, "_sat"}, int'(sat_flag), 0);
    chk({tag, "_rerr"}, int'(range_err), 0);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; phase_in = '0; phase_valid = 1'b0; sym_align = 1'b0;
    step(0, 1'b0, 1'b0);
    step(0, 1'b0, 1'b0);
    chk_zero("reset");

    // 1: prime then first difference
    rst = 1'b0; en = 1'b1;
    step(0, 1'b0, 1'b0);
    step(10, 1'b1, 1'b0);
    chk("prime_fv", int'(freq_valid), 0);
    step(25, 1'b1, 1'b0);
    chk("first_fv", int'(freq_valid), 1);
    chk("first_fo", int'(freq_out), 15);
    chk("first_sat", int'(sat_flag), 0);
    step(25, 1'b0, 1'b0);
    chk("hold_fv", int'(freq_valid), 0);
    chk("hold_fo", int'(freq_out), 15);

    // 2: wrap-around and clipping
    step(350, 1'b1, 1'b0);
    step(5, 1'b1, 1'b0);
    chk("wrap_pos", int'(freq_out), 15);
    step(350, 1'b1, 1'b0);
    chk("wrap_neg", int'(freq_out), -15);
    step(0, 1'b1, 1'b0);
    chk("pre_sat", int'(sat_flag), 0);
    step(180, 1'b1, 1'b0);
    chk("half_pos", int'(freq_out), 127);
    chk("half_sat", int'(sat_flag), 1);
    step(0, 1'b1, 1'b0);
    chk("half_neg", int'(freq_out), 127);

    // 3: integration over 20 differences
    restart();
    chk("rst_sat_clr", int'(sat_flag), 0);
    cur = 0; step(cur, 1'b1, 1'b0);
    ramp(20, 3);
    chk("sym1_early", int'(bit_valid), 0);
    idle();
    chk("sym1_bv", int'(bit_valid), 1);
    chk("sym1_n", nbits, 1);
    chk("sym1_acc", last_acc, 60);
    chk("sym1_bit", last_bit, 1);
    ramp(20, -2); idle();
    chk("sym2_n", nbits, 2);
    chk("sym2_acc", last_acc, -40);
    chk("sym2_bit", last_bit, 0);
    ramp(20, 0); idle();
    chk("sym3_n", nbits, 3);
    chk("sym3_acc", last_acc, 0);
    chk("sym3_bit", last_bit, 1);

    // 4: sym_align alone and coincident with a completing sample
    restart();
    cur = 0; step(cur, 1'b1, 1'b0);
    ramp(7, 5);
    step(cur, 1'b0, 1'b1);
    ramp(19, 5); idle();
    chk("align_nobit", nbits, 0);
    ramp(1, 5); idle();
    chk("align_n", nbits, 1);
    chk("align_acc", last_acc, 100);
    ramp(19, 1);
    cur = cur + 4; step(cur, 1'b1, 1'b1);
    idle();
    chk("coin_nobit", nbits, 1);
    ramp(19, 2); idle();
    chk("coin_n", nbits, 2);
    chk("coin_acc", last_acc, 42);

    // 5: out-of-range sample dropped
    restart();
    cur = 100; step(cur, 1'b1, 1'b0);
    ramp(1, 10);
    chk("pre_err_fo", int'(freq_out), 10);
    step(400, 1'b1, 1'b0);
    chk("err_fv", int'(freq_valid), 0);
    chk("err_flag", int'(range_err), 1);
    ramp(1, 20);
    chk("post_err_fo", int'(freq_out), 20);
    ramp(18, 1); idle();
    chk("err_n", nbits, 1);
    chk("err_acc", last_acc, 48);
    chk("err_sticky", int'(range_err), 1);

    // 6: reset mid-symbol, then enable drop
    restart();
    cur = 0; step(cur, 1'b1, 1'b0);
    ramp(6, 10);
    step(400, 1'b1, 1'b0);
    ramp(6, 10);
    chk("mid_rerr", int'(range_err), 1);
    rst = 1'b1; step(cur, 1'b0, 1'b0);
    chk_zero("midrst");
    rst = 1'b0;
    step(0, 1'b0, 1'b0);
    cur = 0; step(cur, 1'b1, 1'b0);
    chk("reprime_fv", int'(freq_valid), 0);
    nbits = 0;
    ramp(20, 1); idle();
    chk("re_n", nbits, 1);
    chk("re_acc", last_acc, 20);
    ramp(5, 1);
    en = 1'b0;
    for (int i = 0; i < 5; i++) idle();
    chk("dis_fo", int'(freq_out), 1);
    chk("dis_acc", int'(acc_out), 20);
    en = 1'b1;
    idle();
    cur = 200; step(cur, 1'b1, 1'b0);
    chk("en_prime_fv", int'(freq_valid), 0);
    ramp(19, -1); idle();
    chk("en_nobit", nbits, 1);
    ramp(1, -1); idle();
    chk("en_n", nbits, 2);
    chk("en_acc", last_acc, -20);
    chk("en_bit", last_bit, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/gmsk_freq_disc.md
Name: gmsk_freq_disc

Overview:
- Parametrised GMSK frequency discriminator and symbol slicer.
- Sits after the CORDIC vectoring stage: consumes one phase sample per phase_valid strobe and forms the wrapped phase difference (instantaneous frequency).
- Integrates the differences over one symbol and emits a hard bit decision per symbol.
- Generalises the single-rate, fixed 9-bit/360-degree differentiator to arbitrary phase scale, output width and samples-per-symbol, and adds symbol timing, saturation and error flags.

Parameters:
- PHASE_W, 9: phase_in width (unsigned).
- FULL_SCALE, 360: phase code for one full turn; legal phase_in range is 0..FULL_SCALE-1.
- FREQ_W, 8: signed freq_out width.
- SPS, 20: samples per symbol; 16 kHz sample rate / 800 baud. Must be >= 2.
- ACC_W, FREQ_W+$clog2(SPS)+1: signed integrator width.

Ports:
- clk, in, 1: system clock.
- rst, in, 1: synchronous, active-high reset.
- en, in, 1: block enable.
- phase_in, in, PHASE_W: CORDIC phase sample.
- phase_valid, in, 1: single-cycle strobe; phase_in is valid in that cycle.
- sym_align, in, 1: restart symbol integration (from preamble/timing logic).
- freq_out, out, FREQ_W (signed): wrapped, saturated phase difference.
- freq_valid, out, 1: pulse, one cycle.
- acc_out, out, ACC_W (signed): integrator value at symbol end.
- bit_out, out, 1: hard decision.
- bit_valid, out, 1: pulse, one cycle.
- sat_flag, out, 1: sticky; freq_out was clipped.
- range_err, out, 1: sticky; phase_in >= FULL_SCALE was received.

Behaviour:
- Reset: all outputs are 0, state is IDLE, prev_phase = 0, acc = 0, sym_cnt = 0. Reset is synchronous, takes priority over everything, and aborts any symbol in progress.
- FSM:
  - IDLE: when en=1, go to PRIME.
  - PRIME: the first legal phase_valid stores prev_phase, produces no freq_valid, then go to RUN.
  - RUN: each legal phase_valid produces a difference.
  - In any state, en=0 returns the FSM to IDLE next cycle. Outputs hold, the integrator clears, and re-enable re-primes.
- Illegal sample: phase_in >= FULL_SCALE with phase_valid sets range_err. The sample is dropped: no freq_valid, and prev_phase, acc and sym_cnt are unchanged. range_err clears only on rst.
- Difference: d = phase_in - prev_phase, computed in PHASE_W+2 signed bits.
  - If d > FULL_SCALE/2: d -= FULL_SCALE.
  - Else if d <= -(FULL_SCALE/2): d += FULL_SCALE.
  - Result range is (-FS/2, +FS/2]; exactly +FS/2 is not wrapped, exactly -FS/2 maps to +FS/2.
- Saturation: d is clipped to [-2^(FREQ_W-1), 2^(FREQ_W-1)-1]. Clipping sets sat_flag (sticky until rst).
- Latency: freq_out and freq_valid are registered one cycle after the accepting phase_valid. prev_phase updates in the same edge. freq_out holds between strobes.
- Integrator: on each freq_valid sample, acc += saturated d and sym_cnt += 1. When sym_cnt reaches SPS:
  - acc_out = final sum, bit_out = (sum >= 0), bit_valid pulses one cycle after the corresponding freq_valid, i.e. 2 cycles after the SPS-th phase_valid.
  - acc and sym_cnt then clear.
- ACC_W is sized so the integrator cannot overflow.
- sym_align:
  - Alone: clears acc and sym_cnt next edge; no bit_valid for the partial symbol.
  - Coincident with an accepted sample: that sample's difference starts the new symbol (acc = d, sym_cnt = 1).
  - Coincident with a symbol-completing sample: sym_align wins, and no bit is emitted.
- phase_valid on consecutive cycles is legal; the throughput is one sample per clock.

Test Plan:
1. Reset, en=1, phases 10 then 25 -> no freq_valid for 10; freq_out=15 with freq_valid one cycle after the 25 strobe; sat_flag=0.
2. Wrap: 350 then 5 -> +15; 5 then 350 -> -15; 0 then 180 -> +180 clipped to 127, sat_flag=1; 180 then 0 -> -180 wraps to +180, clipped to 127.
3. Integrate, SPS=20: 21 phases stepping +3 (0,3,...,60) -> acc_out=60, bit_out=1, single bit_valid. The next 20 steps of -2 -> acc_out=-40, bit_out=0. 20 steps of 0 -> acc_out=0, bit_out=1.
4. sym_align after 7 differences -> no bit_valid for those 7; the next bit_valid follows exactly 20 further differences. sym_align coincident with the 20th difference -> no bit for it; acc restarts at that d.
5. phase_in=400 (FULL_SCALE=360) mid-stream -> range_err=1, no freq_valid. The next legal sample differences against the pre-error phase.
6. rst asserted mid-symbol (sym_cnt=12), and separately en dropped for 5 cycles -> all outputs 0 after rst. After re-enable, the first sample only primes, and the first bit_valid follows 20 differences later.
